// File: rtl/bot_upd_pkg.sv
// Shared types for the Rojobot update/interrupt controller.
package bot_upd_pkg;

  localparam int BOT_REG_W = 8;
  localparam int UPD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PEND   = 2'd2
  } upd_state_e;

  // Field order matches the concatenation {locx, locy, sensors, botinfo}
  typedef struct packed {
    logic [BOT_REG_W-1:0] locx;
    logic [BOT_REG_W-1:0] locy;
    logic [BOT_REG_W-1:0] sensors;
    logic [BOT_REG_W-1:0] botinfo;
  } bot_snap_t;

endpackage

// File: rtl/bot_upd_ctrl_sync_rise.sv
// Multi-flop synchronizer plus rising-edge detector for a single async input.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // prev resets low, so an input already high at reset release yields one rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/bot_upd_ctrl.sv
// Bot update controller: synchronizes the update pulse, snapshots the bot
// registers, raises a maskable interrupt and counts updates and overruns.
//
//   state  | meaning
//   IDLE   | no unacknowledged update, waiting for a rise
//   SETTLE | one cycle after the rise; bot registers are latched at its end
//   PEND   | snapshot valid, waiting for CPU ack; further rises are overruns
module bot_upd_ctrl
  import bot_upd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVF_W       = 8,
  parameter bit OVERWRITE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_upd,
  input  logic [BOT_REG_W-1:0] i_locx,
  input  logic [BOT_REG_W-1:0] i_locy,
  input  logic [BOT_REG_W-1:0] i_sensors,
  input  logic [BOT_REG_W-1:0] i_botinfo,
  input  logic                 i_ack,
  input  logic                 i_int_en,
  input  logic                 i_ovf_clr,
  output logic [BOT_REG_W-1:0] o_locx,
  output logic [BOT_REG_W-1:0] o_locy,
  output logic [BOT_REG_W-1:0] o_sensors,
  output logic [BOT_REG_W-1:0] o_botinfo,
  output logic                 o_pending,
  output logic                 o_irq,
  output logic [UPD_CNT_W-1:0] o_upd_cnt,
  output logic [OVF_W-1:0]     o_ovf_cnt
);

  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  upd_state_e           state;
  bot_snap_t            snap;
  bot_snap_t            bot_in;
  logic                 pending;
  logic [UPD_CNT_W-1:0] upd_cnt;
  logic [OVF_W-1:0]     ovf_cnt;
  logic                 upd_rise;
  logic                 overrun;

  sync_rise #(
    .STAGES (SYNC_STAGES)
  ) u_sync_rise (
    .clk  (clk),
    .rstn (rstn),
    .din  (i_upd),
    .rise (upd_rise)
  );

  assign bot_in  = {i_locx, i_locy, i_sensors, i_botinfo};
  assign overrun = (state == PEND) & upd_rise & ~i_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      snap    <= '0;
      pending <= 1'b0;
      upd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_rise) state <= SETTLE;
        end
        SETTLE: begin
          snap    <= bot_in;
          upd_cnt <= upd_cnt + UPD_CNT_W'(1);
          pending <= 1'b1;
          state   <= PEND;
        end
        PEND: begin
          // ack with a coinciding rise is a fresh update, not an overrun
          if (i_ack) begin
            pending <= 1'b0;
            state   <= upd_rise ? SETTLE : IDLE;
          end else if (upd_rise && OVERWRITE) begin
            snap    <= bot_in;
            upd_cnt <= upd_cnt + UPD_CNT_W'(1);
          end
        end
        default: begin
          pending <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else if (i_ovf_clr) begin
      ovf_cnt <= '0;
    end else if (overrun && (ovf_cnt != OVF_MAX)) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  assign o_locx    = snap.locx;
  assign o_locy    = snap.locy;
  assign o_sensors = snap.sensors;
  assign o_botinfo = snap.botinfo;
  assign o_pending = pending;
  assign o_irq     = pending & i_int_en;
  assign o_upd_cnt = upd_cnt;
  assign o_ovf_cnt = ovf_cnt;

endmodule

// File: tb/tb_bot_upd_ctrl.sv
// Directed bench for bot_upd_ctrl; dut0 keeps the first snapshot on overrun,
// dut1 refreshes it. Both share every input.
module tb_bot_upd_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_upd, i_ack, i_int_en, i_ovf_clr;
  logic [7:0] i_locx, i_locy, i_sensors, i_botinfo;

  logic [7:0]  locx0, locy0, sens0, binfo0, ovf0;
  logic [7:0]  locx1, locy1, sens1, binfo1, ovf1;
  logic        pend0, irq0, pend1, irq1;
  logic [15:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bot_upd_ctrl #(.SYNC_STAGES(2), .OVF_W(8), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .i_upd(i_upd),
    .i_locx(i_locx), .i_locy(i_locy), .i_sensors(i_sensors), .i_botinfo(i_botinfo),
    .i_ack(i_ack), .i_int_en(i_int_en), .i_ovf_clr(i_ovf_clr),
    .o_locx(locx0), .o_locy(locy0), .o_sensors(sens0), .o_botinfo(binfo0),
    .o_pending(pend0), .o_irq(irq0), .o_upd_cnt(cnt0), .o_ovf_cnt(ovf0)
  );

  bot_upd_ctrl #(.SYNC_STAGES(2), .OVF_W(8), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .i_upd(i_upd),
    .i_locx(i_locx), .i_locy(i_locy), .i_sensors(i_sensors), .i_botinfo(i_botinfo),
    .i_ack(i_ack), .i_int_en(i_int_en), .i_ovf_clr(i_ovf_clr),
    .o_locx(locx1), .o_locy(locy1), .o_sensors(sens1), .o_botinfo(binfo1),
    .o_pending(pend1), .o_irq(irq1), .o_upd_cnt(cnt1), .o_ovf_cnt(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // leaves the bench 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] s, input logic [7:0] b);
    i_locx = x; i_locy = y; i_sensors = s; i_botinfo = b;
  endtask

  // 3-cycle pulse, then enough idle time that the FSM has settled into PEND
  task automatic upd(input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] s, input logic [7:0] b);
    set_data(x, y, s, b);
    i_upd = 1'b1;
    tick(3);
    i_upd = 1'b0;
    tick(4);
  endtask

  task automatic do_reset;
    #2 rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(2);
  endtask

  initial begin
    rstn = 1'b0;
    i_upd = 1'b0; i_ack = 1'b0; i_int_en = 1'b1; i_ovf_clr = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);

    // reset with random inputs
    repeat (3) begin
      i_upd = 1'($urandom); i_ack = 1'($urandom); i_int_en = 1'($urandom);
      i_ovf_clr = 1'($urandom);
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick(1);
    end
    chk("rst_locx",    {24'd0, locx0},  32'h0);
    chk("rst_locy",    {24'd0, locy0},  32'h0);
    chk("rst_sensors", {24'd0, sens0},  32'h0);
    chk("rst_botinfo", {24'd0, binfo0}, 32'h0);
    chk("rst_pending", {31'd0, pend0},  32'h0);
    chk("rst_irq",     {31'd0, irq0},   32'h0);
    chk("rst_updcnt",  {16'd0, cnt0},   32'h0);
    chk("rst_ovfcnt",  {24'd0, ovf0},   32'h0);
    chk("rst_locx1",   {24'd0, locx1},  32'h0);
    i_upd = 1'b0; i_ack = 1'b0; i_int_en = 1'b1; i_ovf_clr = 1'b0;
    rstn = 1'b1;
    tick(6);
    chk("rel_pending", {31'd0, pend0}, 32'h0);
    chk("rel_updcnt",  {16'd0, cnt0},  32'h0);

    // single update: pending rises after the third edge following first sample
    set_data(8'h12, 8'h34, 8'h5A, 8'h07);
    i_upd = 1'b1;
    tick(3);
    chk("lat_pend_early", {31'd0, pend0}, 32'h0);
    i_upd = 1'b0;
    tick(1);
    chk("lat_pend",   {31'd0, pend0},  32'h1);
    chk("snap_locx",  {24'd0, locx0},  32'h12);
    chk("snap_locy",  {24'd0, locy0},  32'h34);
    chk("snap_sens",  {24'd0, sens0},  32'h5A);
    chk("snap_binfo", {24'd0, binfo0}, 32'h07);
    chk("snap_cnt",   {16'd0, cnt0},   32'h1);
    chk("snap_irq",   {31'd0, irq0},   32'h1);
    tick(3);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    chk("ack_pending", {31'd0, pend0}, 32'h0);
    chk("ack_irq",     {31'd0, irq0},  32'h0);

    // overrun behaviour
    do_reset();
    upd(8'h11, 8'h01, 8'h02, 8'h03);
    upd(8'h22, 8'h04, 8'h05, 8'h06);
    chk("ovr_locx0", {24'd0, locx0}, 32'h11);
    chk("ovr_ovf0",  {24'd0, ovf0},  32'h1);
    chk("ovr_cnt0",  {16'd0, cnt0},  32'h1);
    chk("ovr_pend0", {31'd0, pend0}, 32'h1);
    chk("ovr_locx1", {24'd0, locx1}, 32'h22);
    chk("ovr_cnt1",  {16'd0, cnt1},  32'h2);
    chk("ovr_ovf1",  {24'd0, ovf1},  32'h1);

    for (int i = 0; i < 300; i++) upd(8'(i), 8'h00, 8'h00, 8'h00);
    chk("sat_ovf0",  {24'd0, ovf0},  32'hFF);
    chk("sat_ovf1",  {24'd0, ovf1},  32'hFF);
    chk("sat_cnt0",  {16'd0, cnt0},  32'd1);
    chk("sat_cnt1",  {16'd0, cnt1},  32'd302);
    chk("sat_locx0", {24'd0, locx0}, 32'h11);
    chk("sat_locx1", {24'd0, locx1}, 32'h2B);

    i_ovf_clr = 1'b1;
    tick(1);
    i_ovf_clr = 1'b0;
    chk("clr_ovf0", {24'd0, ovf0}, 32'h0);

    upd(8'h33, 8'h00, 8'h00, 8'h00);
    chk("ovr_after_clr", {24'd0, ovf0}, 32'h1);

    // clear coinciding with an overrun: clear wins
    set_data(8'h44, 8'h00, 8'h00, 8'h00);
    i_upd = 1'b1;
    tick(2);
    i_ovf_clr = 1'b1;
    tick(1);
    i_ovf_clr = 1'b0;
    i_upd = 1'b0;
    chk("clr_vs_ovr0", {24'd0, ovf0}, 32'h0);
    chk("clr_vs_ovr1", {24'd0, ovf1}, 32'h0);
    tick(4);
    chk("clr_vs_cnt1", {16'd0, cnt1}, 32'd304);

    // ack coincident with a rise goes through SETTLE again
    upd(8'h55, 8'h00, 8'h00, 8'h00);
    chk("pre_coin_ovf", {24'd0, ovf0}, 32'h1);
    set_data(8'h5C, 8'hC5, 8'h66, 8'h77);
    i_upd = 1'b1;
    tick(2);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    i_upd = 1'b0;
    chk("coin_settle_pend", {31'd0, pend0}, 32'h0);
    chk("coin_ovf0",        {24'd0, ovf0},  32'h1);
    tick(1);
    chk("coin_pend0", {31'd0, pend0}, 32'h1);
    chk("coin_locx0", {24'd0, locx0}, 32'h5C);
    chk("coin_locy1", {24'd0, locy1}, 32'hC5);
    chk("coin_cnt0",  {16'd0, cnt0},  32'd2);
    chk("coin_cnt1",  {16'd0, cnt1},  32'd306);
    chk("coin_ovf1",  {24'd0, ovf1},  32'h1);
    tick(4);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;

    // interrupt masking
    i_int_en = 1'b0;
    upd(8'h66, 8'h00, 8'h00, 8'h00);
    chk("mask_pend", {31'd0, pend0}, 32'h1);
    chk("mask_irq",  {31'd0, irq0},  32'h0);
    i_int_en = 1'b1;
    #1;
    chk("unmask_irq", {31'd0, irq0}, 32'h1);
    tick(1);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    chk("mask_ack_pend", {31'd0, pend0}, 32'h0);
    tick(2);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    tick(2);
    chk("idle_ack_pend", {31'd0, pend0}, 32'h0);
    chk("idle_ack_cnt",  {16'd0, cnt0},  32'd3);

    // asynchronous reset while pending
    upd(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk("pre_rst_locx", {24'd0, locx0}, 32'hFF);
    #2 rstn = 1'b0;
    #1;
    chk("arst_locx",    {24'd0, locx0},  32'h0);
    chk("arst_botinfo", {24'd0, binfo0}, 32'h0);
    chk("arst_pend",    {31'd0, pend0},  32'h0);
    chk("arst_irq",     {31'd0, irq0},   32'h0);
    chk("arst_cnt1",    {16'd0, cnt1},   32'h0);
    chk("arst_ovf1",    {24'd0, ovf1},   32'h0);

    // update level held across reset release yields exactly one capture
    set_data(8'h3C, 8'h00, 8'h00, 8'h00);
    i_upd = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(10);
    chk("held_cnt0",  {16'd0, cnt0},  32'd1);
    chk("held_pend0", {31'd0, pend0}, 32'h1);
    chk("held_locx0", {24'd0, locx0}, 32'h3C);
    chk("held_ovf0",  {24'd0, ovf0},  32'h0);
    i_upd = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
